// File: rtl/rv32i_types.sv
// Shared types and constants for the branch predictor: 2-bit saturating counters.
package rv32i_types;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;
  localparam ctr_t CTR_MAX   = 2'b11;
  localparam ctr_t CTR_MIN   = 2'b00;

endpackage

// File: rtl/pht_array.sv
// Table of 2-bit saturating counters with one async read port and one update port.
// Simultaneous inc and dec leave the addressed counter unchanged.
module pht_array
  import rv32i_types::*;
#(
  parameter int unsigned IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output ctr_t                 rd_ctr,
  input  logic [IDX_WIDTH-1:0] upd_idx,
  input  logic                 inc,
  input  logic                 dec
);

  localparam int Depth = 2 ** IDX_WIDTH;

  ctr_t mem_q [Depth];
  ctr_t upd_d;

  always_comb begin
    upd_d = mem_q[upd_idx];
    if (inc && !dec && (upd_d != CTR_MAX)) begin
      upd_d = upd_d + 2'd1;
    end else if (dec && !inc && (upd_d != CTR_MIN)) begin
      upd_d = upd_d - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= CTR_RESET;
      end
    end else if (inc ^ dec) begin
      mem_q[upd_idx] <= upd_d;
    end
  end

  assign rd_ctr = mem_q[rd_idx];

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: local (BHT + PHT) and gshare components with a chooser,
// plus the IF->ID prediction/index register that training strobes are applied against.
module tournament_predictor
  import rv32i_types::*;
#(
  parameter int unsigned GHR_WIDTH     = 8,
  parameter int unsigned BHT_IDX_WIDTH = 6,
  parameter int unsigned LHR_WIDTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_id_reg_load,
  input  logic        if_id_reg_flush,
  input  logic        id_br_en,
  input  logic        ghr_load,
  input  logic        bht_load,
  input  logic        increment_pht,
  input  logic        decrement_pht,
  input  logic        increment_tournament_pht,
  input  logic        decrement_tournament_pht,
  output logic        if_br_pr,
  output logic        id_local_pr,
  output logic        id_global_pr,
  output logic        id_br_pr
);

  localparam int BhtDepth = 2 ** BHT_IDX_WIDTH;

  logic [GHR_WIDTH-1:0]     ghr_q;
  logic [LHR_WIDTH-1:0]     bht_q [BhtDepth];

  logic [BHT_IDX_WIDTH-1:0] if_bidx;
  logic [LHR_WIDTH-1:0]     if_lhist;
  logic [GHR_WIDTH-1:0]     if_gidx;
  logic                     if_local_pr;
  logic                     if_global_pr;
  ctr_t                     local_ctr;
  ctr_t                     global_ctr;
  ctr_t                     chooser_ctr;

  logic                     id_local_pr_q;
  logic                     id_global_pr_q;
  logic                     id_br_pr_q;
  logic [BHT_IDX_WIDTH-1:0] id_bidx_q;
  logic [LHR_WIDTH-1:0]     id_lhist_q;
  logic [GHR_WIDTH-1:0]     id_gidx_q;
  logic [GHR_WIDTH-1:0]     id_cidx_q;

  // IF-stage lookup
  assign if_bidx      = if_pc[BHT_IDX_WIDTH+1:2];
  assign if_lhist     = bht_q[if_bidx];
  assign if_gidx      = if_pc[GHR_WIDTH+1:2] ^ ghr_q;
  assign if_local_pr  = local_ctr[1];
  assign if_global_pr = global_ctr[1];
  assign if_br_pr     = chooser_ctr[1] ? if_global_pr : if_local_pr;

  pht_array #(
    .IDX_WIDTH (LHR_WIDTH)
  ) u_lpht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (if_lhist),
    .rd_ctr  (local_ctr),
    .upd_idx (id_lhist_q),
    .inc     (increment_pht),
    .dec     (decrement_pht)
  );

  pht_array #(
    .IDX_WIDTH (GHR_WIDTH)
  ) u_gpht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (if_gidx),
    .rd_ctr  (global_ctr),
    .upd_idx (id_gidx_q),
    .inc     (increment_pht),
    .dec     (decrement_pht)
  );

  // Chooser is indexed by the raw GHR, not the gshare hash.
  pht_array #(
    .IDX_WIDTH (GHR_WIDTH)
  ) u_chooser (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (ghr_q),
    .rd_ctr  (chooser_ctr),
    .upd_idx (id_cidx_q),
    .inc     (increment_tournament_pht),
    .dec     (decrement_tournament_pht)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (ghr_load) begin
      ghr_q <= {ghr_q[GHR_WIDTH-2:0], id_br_en};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BhtDepth; i++) begin
        bht_q[i] <= '0;
      end
    end else if (bht_load) begin
      bht_q[id_bidx_q] <= {bht_q[id_bidx_q][LHR_WIDTH-2:0], id_br_en};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_local_pr_q  <= 1'b0;
      id_global_pr_q <= 1'b0;
      id_br_pr_q     <= 1'b0;
      id_bidx_q      <= '0;
      id_lhist_q     <= '0;
      id_gidx_q      <= '0;
      id_cidx_q      <= '0;
    end else if (if_id_reg_flush) begin
      id_local_pr_q  <= 1'b0;
      id_global_pr_q <= 1'b0;
      id_br_pr_q     <= 1'b0;
      id_bidx_q      <= '0;
      id_lhist_q     <= '0;
      id_gidx_q      <= '0;
      id_cidx_q      <= '0;
    end else if (if_id_reg_load) begin
      id_local_pr_q  <= if_local_pr;
      id_global_pr_q <= if_global_pr;
      id_br_pr_q     <= if_br_pr;
      id_bidx_q      <= if_bidx;
      id_lhist_q     <= if_lhist;
      id_gidx_q      <= if_gidx;
      id_cidx_q      <= ghr_q;
    end
  end

  assign id_local_pr  = id_local_pr_q;
  assign id_global_pr = id_global_pr_q;
  assign id_br_pr     = id_br_pr_q;

  // Upper PC bits and byte offset take no part in indexing.
  logic unused_pc;
  assign unused_pc = ^if_pc;

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed self-checking bench for tournament_predictor.
module tb_tournament_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_id_reg_load;
  logic        if_id_reg_flush;
  logic        id_br_en;
  logic        ghr_load;
  logic        bht_load;
  logic        increment_pht;
  logic        decrement_pht;
  logic        increment_tournament_pht;
  logic        decrement_tournament_pht;
  logic        if_br_pr;
  logic        id_local_pr;
  logic        id_global_pr;
  logic        id_br_pr;

  int checks = 0;
  int errors = 0;

  tournament_predictor dut (
    .clk                      (clk),
    .rst                      (rst),
    .if_pc                    (if_pc),
    .if_id_reg_load           (if_id_reg_load),
    .if_id_reg_flush          (if_id_reg_flush),
    .id_br_en                 (id_br_en),
    .ghr_load                 (ghr_load),
    .bht_load                 (bht_load),
    .increment_pht            (increment_pht),
    .decrement_pht            (decrement_pht),
    .increment_tournament_pht (increment_tournament_pht),
    .decrement_tournament_pht (decrement_tournament_pht),
    .if_br_pr                 (if_br_pr),
    .id_local_pr              (id_local_pr),
    .id_global_pr             (id_global_pr),
    .id_br_pr                 (id_br_pr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic inc;
    logic dec;
    logic exp_pr;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    if_id_reg_load           = 1'b0;
    if_id_reg_flush          = 1'b0;
    ghr_load                 = 1'b0;
    bht_load                 = 1'b0;
    increment_pht            = 1'b0;
    decrement_pht            = 1'b0;
    increment_tournament_pht = 1'b0;
    decrement_tournament_pht = 1'b0;
  endtask

  vec_t pht_vecs [12];

  initial begin
    // Local counter LPHT[0] / GPHT[24] start at 1; expected if_br_pr = counter bit 1.
    pht_vecs[0]  = '{inc: 1'b1, dec: 1'b0, exp_pr: 1'b1};  // 2
    pht_vecs[1]  = '{inc: 1'b1, dec: 1'b0, exp_pr: 1'b1};  // 3
    pht_vecs[2]  = '{inc: 1'b1, dec: 1'b0, exp_pr: 1'b1};  // 3 sat
    pht_vecs[3]  = '{inc: 1'b1, dec: 1'b0, exp_pr: 1'b1};  // 3 sat
    pht_vecs[4]  = '{inc: 1'b0, dec: 1'b1, exp_pr: 1'b1};  // 2
    pht_vecs[5]  = '{inc: 1'b0, dec: 1'b1, exp_pr: 1'b0};  // 1
    pht_vecs[6]  = '{inc: 1'b0, dec: 1'b1, exp_pr: 1'b0};  // 0
    pht_vecs[7]  = '{inc: 1'b0, dec: 1'b1, exp_pr: 1'b0};  // 0 sat
    pht_vecs[8]  = '{inc: 1'b1, dec: 1'b0, exp_pr: 1'b0};  // 1, proves no wrap
    pht_vecs[9]  = '{inc: 1'b1, dec: 1'b0, exp_pr: 1'b1};  // 2
    pht_vecs[10] = '{inc: 1'b1, dec: 1'b1, exp_pr: 1'b1};  // 2 unchanged
    pht_vecs[11] = '{inc: 1'b0, dec: 1'b1, exp_pr: 1'b0};  // 1

    rst      = 1'b0;
    if_pc    = 32'h60;
    id_br_en = 1'b0;
    clear_strobes();
    #1;
    check("reset_if_br_pr", {7'd0, if_br_pr}, 8'd0);
    check("reset_id_br_pr", {7'd0, id_br_pr}, 8'd0);
    check("reset_id_local", {7'd0, id_local_pr}, 8'd0);
    check("reset_id_global", {7'd0, id_global_pr}, 8'd0);

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Capture pc 0x60 with GHR=0: lhist=0, gidx=0x18, cidx=0.
    if_id_reg_load = 1'b1;
    step();
    if_id_reg_load = 1'b0;

    foreach (pht_vecs[i]) begin
      increment_pht = pht_vecs[i].inc;
      decrement_pht = pht_vecs[i].dec;
      step();
      clear_strobes();
      check($sformatf("pht_vec%0d", i), {7'd0, if_br_pr}, {7'd0, pht_vecs[i].exp_pr});
    end

    // Diverge local and global: GHR=1 -> gidx=0x19, cidx=1.
    id_br_en = 1'b1;
    ghr_load = 1'b1;
    step();
    clear_strobes();
    if_id_reg_load = 1'b1;
    step();
    clear_strobes();
    increment_pht = 1'b1;
    step();
    step();
    clear_strobes();
    // LPHT[0]=3, GPHT[0x19]=3; now move BHT[24] to history 1 (LPHT[1]=1).
    bht_load = 1'b1;
    step();
    clear_strobes();
    check("diverge_if_pr_local", {7'd0, if_br_pr}, 8'd0);
    if_id_reg_load = 1'b1;
    step();
    clear_strobes();
    check("diverge_id_local", {7'd0, id_local_pr}, 8'd0);
    check("diverge_id_global", {7'd0, id_global_pr}, 8'd1);
    check("diverge_id_br", {7'd0, id_br_pr}, 8'd0);

    // Chooser[1]: 1 -> 2 -> 3 selects global.
    increment_tournament_pht = 1'b1;
    step();
    check("chooser_inc1", {7'd0, if_br_pr}, 8'd1);
    step();
    clear_strobes();
    check("chooser_inc2", {7'd0, if_br_pr}, 8'd1);

    // Flush beats load.
    if_id_reg_flush = 1'b1;
    if_id_reg_load  = 1'b1;
    step();
    clear_strobes();
    check("flush_id_br", {7'd0, id_br_pr}, 8'd0);
    check("flush_id_global", {7'd0, id_global_pr}, 8'd0);
    if_id_reg_load = 1'b1;
    step();
    clear_strobes();
    check("reload_id_br", {7'd0, id_br_pr}, 8'd1);
    check("reload_id_global", {7'd0, id_global_pr}, 8'd1);
    if_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_id_br", i), {7'd0, id_br_pr}, 8'd1);
      check($sformatf("hold%0d_id_local", i), {7'd0, id_local_pr}, 8'd0);
    end
    if_pc = 32'h60;

    // Both chooser strobes: stays 3; then 2 (global) and 1 (local).
    increment_tournament_pht = 1'b1;
    decrement_tournament_pht = 1'b1;
    step();
    clear_strobes();
    check("chooser_both", {7'd0, if_br_pr}, 8'd1);
    decrement_tournament_pht = 1'b1;
    step();
    check("chooser_dec1", {7'd0, if_br_pr}, 8'd1);
    step();
    clear_strobes();
    check("chooser_dec2", {7'd0, if_br_pr}, 8'd0);

    // Async reset in the middle of training.
    increment_tournament_pht = 1'b1;
    increment_pht            = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_if_br_pr", {7'd0, if_br_pr}, 8'd0);
    check("midrst_id_br", {7'd0, id_br_pr}, 8'd0);
    check("midrst_id_local", {7'd0, id_local_pr}, 8'd0);
    check("midrst_ghr", dut.ghr_q, 8'h00);
    clear_strobes();
    step();
    rst = 1'b1;
    check("postrst_if_br_pr", {7'd0, if_br_pr}, 8'd0);
    // One increment from the reset value 01 must flip the prediction.
    if_id_reg_load = 1'b1;
    step();
    clear_strobes();
    increment_pht = 1'b1;
    step();
    clear_strobes();
    check("postrst_one_inc", {7'd0, if_br_pr}, 8'd1);

    // GHR wrap.
    id_br_en = 1'b1;
    ghr_load = 1'b1;
    repeat (9) step();
    clear_strobes();
    check("ghr_all_ones", dut.ghr_q, 8'hFF);
    id_br_en = 1'b0;
    ghr_load = 1'b1;
    step();
    clear_strobes();
    check("ghr_shift_zero", dut.ghr_q, 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
